fft_sched: RTL and testbench

FFT_SCHED -- requirements
Module: fft_sched

---
 rtl/fft_sched.sv | 131 +++++++++++++
 tb/tb_fft_sched.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_sched.sv
// fft_sched: in-place radix-2 FFT pass scheduler. Issues butterfly reads stage by stage
// and retires the matching writebacks in issue order through a small address FIFO.
module fft_sched #(
    parameter int N          = 256,
    parameter int LOGN       = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [$clog2(LOGN):0] stage,
    output logic                  rd_en,
    output logic [LOGN-1:0]       rd_addr_a,
    output logic [LOGN-1:0]       rd_addr_b,
    output logic [LOGN-2:0]       tw_addr,
    output logic                  bf_valid,
    input  logic                  bf_valid_out,
    output logic                  wr_en,
    output logic [LOGN-1:0]       wr_addr_a,
    output logic [LOGN-1:0]       wr_addr_b
);
    localparam int SW    = $clog2(LOGN) + 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [SW-1:0]    LAST_STAGE = SW'(LOGN - 1);
    localparam logic [LOGN-2:0]  J_LAST     = (LOGN-1)'(N / 2 - 1);
    localparam logic [CNT_W-1:0] FULL       = CNT_W'(FIFO_DEPTH);

    logic [1:0]       state;
    logic [LOGN-2:0]  j;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] outstanding;
    logic [LOGN-1:0]  fifo_a [FIFO_DEPTH];
    logic [LOGN-1:0]  fifo_b [FIFO_DEPTH];
    logic [LOGN-1:0]  half;
    logic [LOGN-1:0]  pos;
    logic [LOGN-1:0]  grp;

    // Butterfly (stage, j) touches the pair half apart inside group j>>stage.
    always_comb begin
        half      = LOGN'(1) << stage;
        pos       = {1'b0, j} & (half - LOGN'(1));
        grp       = {1'b0, j} >> stage;
        rd_addr_a = (grp << (stage + 1'b1)) | pos;
        rd_addr_b = rd_addr_a + half;
        tw_addr   = (LOGN-1)'(pos << (LOGN - 1 - int'(stage)));
    end

    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign rd_en     = (state == S_RUN) && (outstanding < FULL);
    assign wr_en     = bf_valid_out && (outstanding != '0);
    assign wr_addr_a = fifo_a[rd_ptr];
    assign wr_addr_b = fifo_b[rd_ptr];

    // NOTE: the address storage has no reset; pointers and count are reset, so stale entries are never read.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            fifo_a[wr_ptr] <= rd_addr_a;
            fifo_b[wr_ptr] <= rd_addr_b;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state uses <= so every update in this block sees the same pre-edge values.
        if (rst) begin
            state       <= S_IDLE;
            stage       <= '0;
            j           <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            outstanding <= '0;
            err         <= 1'b0;
            bf_valid    <= 1'b0;
        end else begin
            bf_valid <= rd_en;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_RUN;
                        stage <= '0;
                        j     <= '0;
                    end
                end
                S_RUN: begin
                    if (rd_en) begin
                        j <= j + 1'b1;
                        if (j == J_LAST) state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // Next stage reads only after every write of this stage has retired.
                    if (outstanding == '0) begin
                        if (stage == LAST_STAGE) begin
                            state <= S_DONE;
                        end else begin
                            stage <= stage + 1'b1;
                            j     <= '0;
                            state <= S_RUN;
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase

            if (rd_en) wr_ptr <= wr_ptr + 1'b1;
            if (wr_en) rd_ptr <= rd_ptr + 1'b1;

            case ({rd_en, wr_en})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: ;
            endcase

            if ((state == S_IDLE) && start) err <= 1'b0;
            if (bf_valid_out && (outstanding == '0)) err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_fft_sched.sv
// tb_fft_sched: scoreboard bench with two schedulers: N=8 with a 4-cycle butterfly stub
// for exact cycle timing, and N=32 with a 10-cycle stub that forces FIFO-full stalls.
module tb_fft_sched;
    localparam int AN    = 8;
    localparam int ALOG  = 3;
    localparam int BN    = 32;
    localparam int BLOG  = 5;
    localparam int DEPTH = 8;
    localparam int ALAT  = 4;
    localparam int BLAT  = 10;

    typedef struct { int s; int a; int b; int tw; } trip_t;
    typedef struct { int a; int b; int due; } wexp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   edges  = 0;
    int   checks = 0;
    int   errors = 0;

    logic                  a_start = 1'b0;
    logic                  a_busy, a_done, a_err, a_rd_en, a_bf_valid, a_wr_en;
    logic                  a_bf_valid_out = 1'b0;
    logic [$clog2(ALOG):0] a_stage;
    logic [ALOG-1:0]       a_rd_addr_a, a_rd_addr_b, a_wr_addr_a, a_wr_addr_b;
    logic [ALOG-2:0]       a_tw_addr;

    logic                  b_start = 1'b0;
    logic                  b_busy, b_done, b_err, b_rd_en, b_bf_valid, b_wr_en;
    logic                  b_bf_valid_out = 1'b0;
    logic [$clog2(BLOG):0] b_stage;
    logic [BLOG-1:0]       b_rd_addr_a, b_rd_addr_b, b_wr_addr_a, b_wr_addr_b;
    logic [BLOG-2:0]       b_tw_addr;

    fft_sched #(.N(AN), .LOGN(ALOG), .FIFO_DEPTH(DEPTH)) u_dut_a (
        .clk(clk), .rst(rst), .start(a_start), .busy(a_busy), .done(a_done), .err(a_err),
        .stage(a_stage), .rd_en(a_rd_en), .rd_addr_a(a_rd_addr_a), .rd_addr_b(a_rd_addr_b),
        .tw_addr(a_tw_addr), .bf_valid(a_bf_valid), .bf_valid_out(a_bf_valid_out),
        .wr_en(a_wr_en), .wr_addr_a(a_wr_addr_a), .wr_addr_b(a_wr_addr_b)
    );

    fft_sched #(.N(BN), .LOGN(BLOG), .FIFO_DEPTH(DEPTH)) u_dut_b (
        .clk(clk), .rst(rst), .start(b_start), .busy(b_busy), .done(b_done), .err(b_err),
        .stage(b_stage), .rd_en(b_rd_en), .rd_addr_a(b_rd_addr_a), .rd_addr_b(b_rd_addr_b),
        .tw_addr(b_tw_addr), .bf_valid(b_bf_valid), .bf_valid_out(b_bf_valid_out),
        .wr_en(b_wr_en), .wr_addr_a(b_wr_addr_a), .wr_addr_b(b_wr_addr_b)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) edges++;

    // Reference: butterfly k of a pass, from plain group/position arithmetic.
    function automatic trip_t model(input int n, input int k);
        trip_t t;
        int    half, idx, grp, pos;
        t.s  = k / (n / 2);
        idx  = k % (n / 2);
        half = 2 ** t.s;
        grp  = idx / half;
        pos  = idx % half;
        t.a  = grp * 2 * half + pos;
        t.b  = t.a + half;
        t.tw = pos * (n / 2) / half;
        return t;
    endfunction

    function automatic logic [63:0] span(input int lo, input int hi);
        logic [63:0] m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Butterfly stubs: bf_valid_out repeats bf_valid LAT cycles later.
    bit a_hist [16];
    bit b_hist [16];
    bit a_inj = 1'b0;

    always @(posedge clk) begin
        #1;
        for (int i = 15; i > 0; i--) begin
            a_hist[i] = a_hist[i-1];
            b_hist[i] = b_hist[i-1];
        end
        a_hist[0]      = a_bf_valid;
        b_hist[0]      = b_bf_valid;
        a_bf_valid_out = a_hist[ALAT] | a_inj;
        b_bf_valid_out = b_hist[BLAT];
    end

    trip_t       a_rd_q [$];
    wexp_t       a_wr_q [$];
    int          a_p = 1 << 30;
    int          a_wr_cnt = 0;
    logic [63:0] a_tr_rd, a_tr_done, a_tr_busy;

    always @(negedge clk) begin : mon_a
        int    cyc;
        trip_t e;
        wexp_t w;
        cyc = edges - a_p + 1;
        if (cyc >= 1 && cyc < 64) begin
            a_tr_rd[cyc]   = a_rd_en;
            a_tr_done[cyc] = a_done;
            a_tr_busy[cyc] = a_busy;
        end
        if (a_wr_en) begin
            a_wr_cnt++;
            check("a_wr_expected", 64'(a_wr_q.size() != 0), 64'd1);
            if (a_wr_q.size() != 0) begin
                w = a_wr_q.pop_front();
                check("a_wr_addr_time", {16'd0, 16'(a_wr_addr_a), 16'(a_wr_addr_b), 16'(edges)},
                      {16'd0, 16'(w.a), 16'(w.b), 16'(w.due)});
            end
        end
        if (a_rd_en) begin
            check("a_rd_expected", 64'(a_rd_q.size() != 0), 64'd1);
            if (a_rd_q.size() != 0) begin
                e = a_rd_q.pop_front();
                check("a_rd_stage_addr_tw",
                      {16'(a_stage), 16'(a_rd_addr_a), 16'(a_rd_addr_b), 16'(a_tw_addr)},
                      {16'(e.s), 16'(e.a), 16'(e.b), 16'(e.tw)});
                w.a = e.a; w.b = e.b; w.due = edges + ALAT + 1;
                a_wr_q.push_back(w);
            end
        end
    end

    trip_t b_rd_q [$];
    wexp_t b_wr_q [$];
    int    b_p = 1 << 30;
    int    b_rd_cnt = 0;
    int    b_first_wr = -1;
    int    b_max_out = 0;
    int    b_rd_cyc [16];

    always @(negedge clk) begin : mon_b
        int    cyc;
        trip_t e;
        wexp_t w;
        cyc = edges - b_p + 1;
        if (b_wr_q.size() > b_max_out) b_max_out = b_wr_q.size();
        if (b_wr_en) begin
            if (b_first_wr < 0) b_first_wr = cyc;
            check("b_wr_expected", 64'(b_wr_q.size() != 0), 64'd1);
            if (b_wr_q.size() != 0) begin
                w = b_wr_q.pop_front();
                check("b_wr_addr_time", {16'd0, 16'(b_wr_addr_a), 16'(b_wr_addr_b), 16'(edges)},
                      {16'd0, 16'(w.a), 16'(w.b), 16'(w.due)});
            end
        end
        if (b_rd_en) begin
            if (b_rd_cnt < 16) b_rd_cyc[b_rd_cnt] = cyc;
            b_rd_cnt++;
            check("b_rd_expected", 64'(b_rd_q.size() != 0), 64'd1);
            if (b_rd_q.size() != 0) begin
                e = b_rd_q.pop_front();
                check("b_rd_stage_addr_tw",
                      {16'(b_stage), 16'(b_rd_addr_a), 16'(b_rd_addr_b), 16'(b_tw_addr)},
                      {16'(e.s), 16'(e.a), 16'(e.b), 16'(e.tw)});
                w.a = e.a; w.b = e.b; w.due = edges + BLAT + 1;
                b_wr_q.push_back(w);
            end
        end
    end

    task automatic start_pass_a();
        for (int k = 0; k < (AN / 2) * ALOG; k++) a_rd_q.push_back(model(AN, k));
        a_p       = edges + 1;
        a_tr_rd   = '0;
        a_tr_done = '0;
        a_tr_busy = '0;
        a_start   = 1'b1;
    endtask

    task automatic run_pass_a(input bit hold);
        start_pass_a();
        tick();
        if (!hold) a_start = 1'b0;
        check("a_err_clear_after_start", 64'(a_err), 64'd0);
        for (int c = 2; c <= 36; c++) begin
            tick();
            if (c == 31) a_start = 1'b0;
        end
        check("a_rd_en_cycles", a_tr_rd, span(1, 4) | span(11, 14) | span(21, 24));
        check("a_done_cycles", a_tr_done, span(31, 31));
        check("a_busy_cycles", a_tr_busy, span(1, 31));
        check("a_queues_drained", 64'(a_rd_q.size() + a_wr_q.size()), 64'd0);
    endtask

    task automatic run_pass_b();
        bit seen = 1'b0;
        for (int k = 0; k < (BN / 2) * BLOG; k++) b_rd_q.push_back(model(BN, k));
        b_p     = edges + 1;
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        for (int c = 0; c < 3000 && !seen; c++) begin
            tick();
            seen = b_done;
        end
        check("b_done_reached", 64'(seen), 64'd1);
        check("b_eighth_issue_cycle", 64'(b_rd_cyc[7]), 64'd8);
        check("b_first_write_cycle", 64'(b_first_wr), 64'(2 + BLAT));
        check("b_resume_cycle", 64'(b_rd_cyc[8]), 64'(2 + BLAT + 1));
        check("b_max_outstanding", 64'(b_max_out), 64'(DEPTH));
        check("b_queues_drained", 64'(b_rd_q.size() + b_wr_q.size()), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int wr0;
        repeat (3) tick();
        check("a_reset_outputs", 64'({a_busy, a_done, a_err, a_rd_en, a_bf_valid, a_wr_en, a_stage}), 64'd0);
        check("b_reset_outputs", 64'({b_busy, b_done, b_err, b_rd_en, b_bf_valid, b_wr_en, b_stage}), 64'd0);
        rst = 1'b0;
        tick();

        run_pass_a(1'b0);
        run_pass_b();

        // Stray butterfly result while idle.
        repeat (2) tick();
        a_inj = 1'b1;
        tick();
        check("a_stray_no_write", 64'(a_wr_en), 64'd0);
        a_inj = 1'b0;
        tick();
        check("a_stray_sets_err", 64'(a_err), 64'd1);
        repeat (3) tick();
        check("a_err_sticky", 64'(a_err), 64'd1);
        run_pass_a(1'b0);

        // Reset in the middle of stage 1.
        start_pass_a();
        tick();
        a_start = 1'b0;
        repeat (12) tick();
        rst = 1'b1;
        tick();
        check("a_mid_reset_outputs", 64'({a_busy, a_done, a_err, a_rd_en, a_bf_valid, a_wr_en, a_stage}), 64'd0);
        rst = 1'b0;
        a_rd_q.delete();
        a_wr_q.delete();
        wr0 = a_wr_cnt;
        repeat (5) tick();
        check("a_stale_no_write", 64'(a_wr_cnt - wr0), 64'd0);
        check("a_stale_sets_err", 64'(a_err), 64'd1);
        run_pass_a(1'b0);

        // start held high for a whole pass, then a fresh pass from idle.
        run_pass_a(1'b1);
        run_pass_a(1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
